// File: rtl/instr_issue_queue.sv
// In-order instruction queue and issue stage: a circular FIFO of 12-bit instructions whose
// head is issued to the load buffer, adder RS or multiplier RS once that unit reports room.
module instr_issue_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [11:0]      in_instr,
  output logic             in_ready,
  input  logic             ld_free,
  input  logic             add_free,
  input  logic             mul_free,
  output logic             issue_valid,
  output logic [1:0]       issue_unit,
  output logic [11:0]      issue_instr,
  output logic             illegal,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      issued_total
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    UNIT_LD  = 2'd0,
    UNIT_ADD = 2'd1,
    UNIT_MUL = 2'd2
  } unit_e;

  logic [11:0]      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [11:0]      head_instr;
  unit_e            head_unit;
  logic             head_legal;
  logic             head_free;
  logic             do_push;
  logic             do_pop;

  assign head_instr = mem[head];

  // NOTE: every output of a combinational block gets a default first, otherwise
  // the opcodes that hit no case arm would infer latches.
  always_comb begin
    head_unit  = UNIT_LD;
    head_legal = 1'b0;
    head_free  = 1'b0;
    case (head_instr[11:9])
      3'b001: begin
        head_unit  = UNIT_LD;
        head_legal = 1'b1;
        head_free  = ld_free;
      end
      3'b010, 3'b011: begin
        head_unit  = UNIT_ADD;
        head_legal = 1'b1;
        head_free  = add_free;
      end
      3'b100, 3'b101: begin
        head_unit  = UNIT_MUL;
        head_legal = 1'b1;
        head_free  = mul_free;
      end
      default: ;
    endcase
  end

  // No bypass: a full queue refuses the push even if the head pops this cycle.
  assign in_ready = (count < CNT_W'(DEPTH)) && !flush;
  assign do_push  = in_valid && in_ready;
  // Illegal heads are dropped regardless of the free inputs.
  assign do_pop   = (count != '0) && !flush && (!head_legal || head_free);

  // NOTE: the storage array has no reset; count/pointers alone define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[tail] <= in_instr;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      issue_valid  <= 1'b0;
      issue_unit   <= 2'd0;
      issue_instr  <= 12'd0;
      illegal      <= 1'b0;
      issued_total <= 16'd0;
    end else if (flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);

      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      issue_valid <= do_pop && head_legal;
      illegal     <= do_pop && !head_legal;
      if (do_pop && head_legal) begin
        issue_unit   <= head_unit;
        issue_instr  <= head_instr;
        issued_total <= issued_total + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: stimulus queues the expected issue/illegal events,
// an independent negedge monitor pops and compares them against the DUT outputs.
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, ld_free, add_free, mul_free;
  logic [11:0] in_instr;
  logic        in_ready, issue_valid, illegal;
  logic [1:0]  issue_unit;
  logic [11:0] issue_instr;
  logic [3:0]  count;
  logic [15:0] issued_total;

  typedef struct {
    bit          ill;
    logic [1:0]  unit;
    logic [11:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .ld_free(ld_free), .add_free(add_free), .mul_free(mul_free),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_instr(issue_instr),
    .illegal(illegal), .count(count), .issued_total(issued_total)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [1:0] unit, input logic [11:0] instr);
    exp_t e;
    e.ill = 1'b0; e.unit = unit; e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic expect_illegal();
    exp_t e;
    e.ill = 1'b1; e.unit = 2'd0; e.instr = 12'd0;
    exp_q.push_back(e);
  endtask

  task automatic set_free(input logic l, input logic a, input logic m);
    ld_free = l; add_free = a; mul_free = m;
  endtask

  // Monitor: every issue or illegal pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (issue_valid || illegal) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got valid=%0b illegal=%0b instr=%0h expected none at %0t",
                 issue_valid, illegal, issue_instr, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_kind", {30'd0, illegal, issue_valid}, e.ill ? 32'd2 : 32'd1);
        if (!e.ill) begin
          check("mon_unit", {30'd0, issue_unit}, {30'd0, e.unit});
          check("mon_instr", {20'd0, issue_instr}, {20'd0, e.instr});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [11:0] fill_tbl [8] = '{12'h2C1, 12'h4D2, 12'h6E3, 12'h8F4,
                                12'hA05, 12'h216, 12'h427, 12'h838};
  logic [1:0]  fill_unit[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd2};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 12'd0;
    set_free(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_issue_valid", {31'd0, issue_valid}, 0);
    check("rst_issue_unit", {30'd0, issue_unit}, 0);
    check("rst_issue_instr", {20'd0, issue_instr}, 0);
    check("rst_illegal", {31'd0, illegal}, 0);
    check("rst_count", {28'd0, count}, 0);
    check("rst_issued_total", {16'd0, issued_total}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // Single ADD, minimum latency
    set_free(1'b0, 1'b1, 1'b0);
    expect_issue(2'd1, 12'h4C5);
    in_valid = 1'b1; in_instr = 12'h4C5;
    tick();
    in_valid = 1'b0;
    check("lat_count_after_push", {28'd0, count}, 1);
    check("lat_not_early", {31'd0, issue_valid}, 0);
    tick();
    check("lat_issue_valid", {31'd0, issue_valid}, 1);
    check("lat_count_drained", {28'd0, count}, 0);
    check("lat_issued_total", {16'd0, issued_total}, 1);
    tick();
    check("lat_pulse_single", {31'd0, issue_valid}, 0);

    // MUL stalls, LOAD blocked behind it
    set_free(1'b1, 1'b0, 1'b0);
    expect_issue(2'd2, 12'h853);
    expect_issue(2'd0, 12'h300);
    in_valid = 1'b1; in_instr = 12'h853; tick();
    in_instr = 12'h300; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_issue", {31'd0, issue_valid}, 0);
    end
    check("stall_count", {28'd0, count}, 2);
    mul_free = 1'b1;
    tick();
    check("stall_mul_issue", {31'd0, issue_valid}, 1);
    check("stall_mul_unit", {30'd0, issue_unit}, 2);
    tick();
    check("stall_load_issue", {31'd0, issue_valid}, 1);
    check("stall_load_unit", {30'd0, issue_unit}, 0);
    check("stall_count_end", {28'd0, count}, 0);
    check("stall_issued_total", {16'd0, issued_total}, 3);

    // Fill to DEPTH, reject 9th, drain back-to-back
    set_free(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = fill_tbl[i];
      expect_issue(fill_unit[i], fill_tbl[i]);
      tick();
    end
    check("full_count", {28'd0, count}, 8);
    check("full_in_ready", {31'd0, in_ready}, 0);
    in_instr = 12'h4FF;
    tick();
    in_valid = 1'b0;
    check("full_ninth_ignored", {28'd0, count}, 8);
    set_free(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_b2b", {31'd0, issue_valid}, 1);
    end
    check("drain_count", {28'd0, count}, 0);
    check("drain_issued_total", {16'd0, issued_total}, 11);
    tick();
    check("drain_done", {31'd0, issue_valid}, 0);

    // Illegal head dropped, then SUB
    expect_illegal();
    expect_issue(2'd1, 12'h6AB);
    in_valid = 1'b1; in_instr = 12'hE00; tick();
    in_instr = 12'h6AB; tick();
    in_valid = 1'b0;
    check("ill_pulse", {31'd0, illegal}, 1);
    check("ill_no_issue", {31'd0, issue_valid}, 0);
    check("ill_count", {28'd0, count}, 1);
    tick();
    check("ill_sub_issue", {31'd0, issue_valid}, 1);
    check("ill_pulse_single", {31'd0, illegal}, 0);
    check("ill_sub_unit", {30'd0, issue_unit}, 1);
    check("ill_issued_total", {16'd0, issued_total}, 12);

    // Flush with a concurrent push
    set_free(1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b1;
    in_instr = 12'h401; tick();
    in_instr = 12'h412; tick();
    in_instr = 12'h423; tick();
    in_instr = 12'h434; tick();
    check("flush_pre_count", {28'd0, count}, 4);
    flush = 1'b1; in_instr = 12'h4C5;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", {28'd0, count}, 0);
    check("flush_no_issue", {31'd0, issue_valid}, 0);
    check("flush_total_kept", {16'd0, issued_total}, 12);
    set_free(1'b1, 1'b1, 1'b1);
    tick(); tick();
    check("flush_push_discarded", {28'd0, count}, 0);

    // Simultaneous push/pop at count 3, then mid-stream reset
    set_free(1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_instr = 12'h441; tick();
    in_instr = 12'h452; tick();
    in_instr = 12'h463; tick();
    check("pp_pre_count", {28'd0, count}, 3);
    add_free = 1'b1;
    expect_issue(2'd1, 12'h441);
    in_instr = 12'h474;
    tick();
    add_free = 1'b0; in_valid = 1'b0;
    check("pp_count_same", {28'd0, count}, 3);
    check("pp_issue", {31'd0, issue_valid}, 1);
    check("pp_issued_total", {16'd0, issued_total}, 13);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_issue_valid", {31'd0, issue_valid}, 0);
    check("mrst_issue_unit", {30'd0, issue_unit}, 0);
    check("mrst_issue_instr", {20'd0, issue_instr}, 0);
    check("mrst_illegal", {31'd0, illegal}, 0);
    check("mrst_count", {28'd0, count}, 0);
    check("mrst_issued_total", {16'd0, issued_total}, 0);
    check("mrst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b0;
    set_free(1'b1, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("mrst_stays_empty", {28'd0, count}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
